tx_feeder: RTL
==============

Name: tx_feeder

Overview:
- Buffered byte source sitting directly upstream of the UART transmitter controller (tx_ctl).
- Accepts bytes from the system side into an internal FIFO.
- Presents bytes one at a time on din/din_rdy, pacing delivery with the transmitter's tx_rdy.
- Lets producers burst bytes without watching transmitter busy/idle timing.

Parameters:
- DEPTH, 16, FIFO capacity in bytes (power of two, minimum 2).
- AW, 4, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock, shared with tx_ctl.
- rst  in  1  asynchronous, active-low reset.
- wr_data  in  8  byte to enqueue.
- wr_en  in  1  enqueue strobe, one byte per cycle while high.
- ovf_clr  in  1  clears the overflow flag.
- tx_rdy  in  1  transmitter idle (1) or busy (0), from tx_ctl.
- din  out  8  byte offered to the transmitter.
- din_rdy  out  1  din valid, held until the transmitter accepts it.
- full  out  1  FIFO holds DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- count  out  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset (rst=0, async): pointers=0, count=0, empty=1, full=0, overflow=0, din=8'h00, din_rdy=0, FSM=IDLE.
- FIFO: write pointer and read pointer of AW bits, both wrapping modulo DEPTH; count tracked separately.
  - full = (count==DEPTH); empty = (count==0); both registered consistently with count.
- Write acceptance:
  - wr_en && !full: store wr_data at wptr, wptr+1, count+1.
  - wr_en && full: byte dropped, overflow<=1. This applies even if a pop occurs the same cycle; full is evaluated pre-edge.
  - ovf_clr clears overflow. If a dropped write and ovf_clr occur in the same cycle, the set wins.
- Simultaneous write and pop with 0<count<DEPTH: both happen, count unchanged.
- Pop is never issued when empty.
- FSM states:
  - IDLE: if !empty && tx_rdy, pop the head into din, set din_rdy<=1, go to ISSUE. Otherwise stay.
  - ISSUE: din_rdy=1 and din held stable. When tx_rdy sampled 0 (transmitter took the byte), din_rdy<=0 and go to BUSY. No timeout.
  - BUSY: wait for tx_rdy sampled 1, then go to IDLE.
- Latency:
  - Byte written into an empty FIFO at edge N: count=1 after N, pop at edge N+1, din_rdy=1 after N+1.
  - Back-to-back bytes: the next pop happens one cycle after tx_rdy returns high (BUSY->IDLE, then IDLE pops).
- Exactly one din_rdy assertion per byte. A byte is never re-sent or skipped.
- din changes only on the IDLE pop edge. It keeps its last value otherwise.
- Reset mid-transfer: everything returns to reset values, buffered bytes are discarded, din_rdy drops immediately (async).
- tx_rdy low while in IDLE: no pop; the FIFO keeps filling.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ISSUE=2'd1, BUSY=2'd2) and the default DEPTH constant.
- Sub-module byte_fifo:
  - Synchronous FIFO (storage, pointers, count, full/empty, overflow).
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, full, empty, count, overflow, ovf_clr.
- tx_feeder instantiates byte_fifo and holds the FSM and din register.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then release, with tx_rdy=1 -> din_rdy=0, empty=1, count=0, overflow=0 throughout.
- Single byte: write 8'hA5 at edge N, tx_rdy=1 -> din=8'hA5 and din_rdy=1 after N+1.
  - Hold tx_rdy=1 for 5 more cycles -> din_rdy stays 1.
  - Drop tx_rdy -> din_rdy=0 next edge.
  - Raise tx_rdy -> count=0, no second assertion.
- Burst: write 8'h01..8'h05 back-to-back with a bench transmitter model (busy 10 cycles per byte) -> five din_rdy assertions, din=01,02,03,04,05 in order, count peaks at 4.
- Overflow: tx_rdy=0, write 17 bytes with DEPTH=16 -> full=1 after 16 writes, 17th dropped, overflow=1, count=16. Then ovf_clr=1 for 1 cycle -> overflow=0.
- Wrap-around: alternate 20 writes and pops across the pointer wrap -> output sequence matches input, count never exceeds DEPTH, full/empty correct at 0 and 16.
- Reset mid-operation: rst=0 while in ISSUE with count=3 -> din_rdy=0 and count=0 immediately. After release, no byte emitted until a new write.

Source files
------------

// File: rtl/tx_feeder_pkg.sv
// Shared constants for the transmit feeder: FSM state encoding and default FIFO depth.
package tx_feeder_pkg;

  localparam int DEFAULT_DEPTH = 16;

  // Handshake FSM states; kept as plain constants so older tools that
  // dislike enums in ports and parameters can still read them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with a separate occupancy counter, registered
// full/empty flags and a sticky overflow flag for dropped writes.
module byte_fifo
  import tx_feeder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr
);

  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;
  logic [AW:0]   count_next;

  // A write into a full FIFO is dropped even if a pop happens on the same edge,
  // because full reflects the occupancy before the edge.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rptr];

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count;
    if (do_wr && !do_rd) begin
      count_next = count + 1'b1;
    end else if (!do_wr && do_rd) begin
      count_next = count - 1'b1;
    end
  end

  // Pointers, occupancy and flags; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_wr) begin
        wptr <= wptr + 1'b1;
      end
      if (do_rd) begin
        rptr <= rptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
      empty <= (count_next == '0);
    end
  end

  // Sticky overflow; a dropped write beats a clear arriving on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= wr_data;
    end
  end

endmodule

// File: rtl/tx_feeder.sv
// Buffered byte source for the UART transmitter: queues bytes from the
// system side and offers them one at a time, paced by tx_rdy.
module tx_feeder
  import tx_feeder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  input  logic          ovf_clr,
  input  logic          tx_rdy,
  output logic [7:0]    din,
  output logic          din_rdy,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  logic [1:0] state;
  logic       rd_en;
  logic [7:0] rd_data;

  // Pop only from IDLE with data waiting and an idle transmitter, so each
  // byte is handed over exactly once.
  assign rd_en = (state == ST_IDLE) && !empty && tx_rdy;

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  // Handshake FSM: offer a byte, wait for the transmitter to go busy, then wait for it to finish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      din     <= 8'h00;
      din_rdy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_en) begin
            din     <= rd_data;
            din_rdy <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!tx_rdy) begin
            din_rdy <= 1'b0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (tx_rdy) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          din_rdy <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
